fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 130 +++++++++++++
 tb/tb_fetch_queue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction queue between the IBus response and Decode.
// Each entry holds {pc, inst, fault}. A redirect (flush) discards every queued
// entry together with the word offered in the same cycle.
// Optional feature: define FETCH_QUEUE_BYPASS_EN so that a word arriving at an
// empty queue is shown to Decode in the same cycle. If Decode also takes it,
// the word is never written into storage.
module fetch_queue #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enq_valid,
    input  logic [31:0]              enq_pc,
    input  logic [31:0]              enq_inst,
    input  logic                     enq_fault,
    output logic                     enq_ready,
    output logic                     deq_valid,
    output logic [31:0]              deq_pc,
    output logic [31:0]              deq_inst,
    output logic                     deq_fault,
    input  logic                     deq_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Storage is not reset. The pointers and count alone decide which entries are live.
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   inst_mem  [DEPTH];
    logic          fault_mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic          stored_valid;
    logic          wr_en;
    logic          rd_en;
`ifdef FETCH_QUEUE_BYPASS_EN
    logic          bypass_hit;
    logic          bypass_take;
`endif

    // Handshake qualification. A full queue never accepts, even while it is draining.
    always_comb begin
        stored_valid = (count_q != '0);
        enq_ready    = (count_q != FULL_COUNT);
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_hit   = (count_q == '0) && enq_valid && !flush;
        bypass_take  = bypass_hit && deq_ready;
        wr_en        = enq_valid && enq_ready && !flush && !bypass_take;
`else
        wr_en        = enq_valid && enq_ready && !flush;
`endif
        rd_en        = stored_valid && deq_ready && !flush;
    end

    // Present the head entry, or the bypassed word, to Decode. Outputs are zero when nothing is valid.
    always_comb begin
        deq_valid = 1'b0;
        deq_pc    = '0;
        deq_inst  = '0;
        deq_fault = 1'b0;
        if (stored_valid && !flush) begin
            deq_valid = 1'b1;
            deq_pc    = pc_mem[rd_ptr_q];
            deq_inst  = inst_mem[rd_ptr_q];
            deq_fault = fault_mem[rd_ptr_q];
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        else if (bypass_hit) begin
            deq_valid = 1'b1;
            deq_pc    = enq_pc;
            deq_inst  = enq_inst;
            deq_fault = enq_fault;
        end
`endif
    end

    // Next pointer and count values. Flush collapses the read pointer onto the write pointer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers. These clear asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write at the tail slot.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr_q]    <= enq_pc;
            inst_mem[wr_ptr_q]  <= enq_inst;
            fault_mem[wr_ptr_q] <= enq_fault;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue. A queue-based reference model is compared
// against the DUT on every negative clock edge. Directed scenarios check
// hand-computed values, and a randomized phase follows them.
module tb_fetch_queue;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enq_valid = 1'b0;
    logic [31:0]       enq_pc = '0;
    logic [31:0]       enq_inst = '0;
    logic              enq_fault = 1'b0;
    logic              enq_ready;
    logic              deq_valid;
    logic [31:0]       deq_pc;
    logic [31:0]       deq_inst;
    logic              deq_fault;
    logic              deq_ready = 1'b0;
    logic              flush = 1'b0;
    logic [CW-1:0]     count;

    int                total_checks = 0;
    int                passed_checks = 0;

    entry_t            model_q[$];
    logic [31:0]       deq_log[$];

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enq_valid (enq_valid),
        .enq_pc    (enq_pc),
        .enq_inst  (enq_inst),
        .enq_fault (enq_fault),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_pc    (deq_pc),
        .deq_inst  (deq_inst),
        .deq_fault (deq_fault),
        .deq_ready (deq_ready),
        .flush     (flush),
        .count     (count)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual === expected) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: compute expected outputs from the stored list and the current inputs, then advance it
    always @(negedge clk) begin
        int          n;
        logic        exp_dv;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic        exp_fault;
        logic        bypass;
        logic        pushed;
        if (!rst_n) begin
            model_q.delete();
            checkOutput("rst_count", 32'(count), 32'd0);
            checkOutput("rst_deq_valid", 32'(deq_valid), 32'd0);
            checkOutput("rst_enq_ready", 32'(enq_ready), 32'd1);
            checkOutput("rst_deq_pc", deq_pc, 32'd0);
        end else begin
            n         = model_q.size();
            exp_dv    = 1'b0;
            exp_pc    = '0;
            exp_inst  = '0;
            exp_fault = 1'b0;
            bypass    = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
            bypass = (n == 0) && enq_valid && !flush;
`endif
            if (n != 0 && !flush) begin
                exp_dv    = 1'b1;
                exp_pc    = model_q[0].pc;
                exp_inst  = model_q[0].inst;
                exp_fault = model_q[0].fault;
            end else if (bypass) begin
                exp_dv    = 1'b1;
                exp_pc    = enq_pc;
                exp_inst  = enq_inst;
                exp_fault = enq_fault;
            end
            checkOutput("count", 32'(count), 32'(n));
            checkOutput("enq_ready", 32'(enq_ready), 32'(n != DEPTH));
            checkOutput("deq_valid", 32'(deq_valid), 32'(exp_dv));
            checkOutput("deq_pc", deq_pc, exp_pc);
            checkOutput("deq_inst", deq_inst, exp_inst);
            checkOutput("deq_fault", 32'(deq_fault), 32'(exp_fault));
            if (deq_valid && deq_ready && !flush) begin
                deq_log.push_back(deq_pc);
            end
            if (flush) begin
                model_q.delete();
            end else begin
                pushed = 1'b0;
                if (n != 0 && deq_ready) begin
                    void'(model_q.pop_front());
                end
                if (enq_valid && n != DEPTH && !(bypass && deq_ready)) begin
                    pushed = 1'b1;
                end
                if (pushed) begin
                    model_q.push_back('{pc: enq_pc, inst: enq_inst, fault: enq_fault});
                end
            end
        end
    end

    // Drive one cycle of inputs after a rising edge, then return once the outputs have settled
    task automatic applyStimulus(input logic ev, input logic [31:0] pc, input logic [31:0] inst,
                                 input logic fault, input logic dr, input logic fl);
        @(posedge clk);
        #1;
        enq_valid = ev;
        enq_pc    = pc;
        enq_inst  = inst;
        enq_fault = fault;
        deq_ready = dr;
        flush     = fl;
        @(negedge clk);
        #1;
    endtask

    task automatic idleCycle(input logic dr);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, dr, 1'b0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        flush     = 1'b0;
        #1;
        checkOutput("async_rst_count", 32'(count), 32'd0);
        checkOutput("async_rst_enq_ready", 32'(enq_ready), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        deq_log.delete();
    endtask

    initial begin
        logic ev, dr, fl;
        $display("[TB] fetch_queue bench start");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // First enqueue appears on the next cycle
        doReset();
        applyStimulus(1'b1, 32'h0, 32'h13, 1'b0, 1'b0, 1'b0);
        idleCycle(1'b0);
        checkOutput("t32_count", 32'(count), 32'd1);
        checkOutput("t32_deq_valid", 32'(deq_valid), 32'd1);
        checkOutput("t32_deq_pc", deq_pc, 32'h0);
        checkOutput("t32_deq_inst", deq_inst, 32'h13);

        // Fill to DEPTH=2, third word dropped, drain in order
        doReset();
        applyStimulus(1'b1, 32'h100, 32'hA0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h104, 32'hA4, 1'b0, 1'b0, 1'b0);
        checkOutput("t33_ready_one", 32'(enq_ready), 32'd1);
        applyStimulus(1'b1, 32'h108, 32'hA8, 1'b0, 1'b0, 1'b0);
        checkOutput("t33_ready_full", 32'(enq_ready), 32'd0);
        checkOutput("t33_count_full", 32'(count), 32'd2);
        idleCycle(1'b1);
        checkOutput("t33_head0", deq_pc, 32'h100);
        idleCycle(1'b1);
        checkOutput("t33_head1", deq_pc, 32'h104);
        idleCycle(1'b1);
        checkOutput("t33_empty", 32'(deq_valid), 32'd0);
        checkOutput("t33_log_size", 32'(deq_log.size()), 32'd2);

        // Flush while full drops the queue contents and the word offered with the flush
        doReset();
        applyStimulus(1'b1, 32'h1F0, 32'h1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h1F4, 32'h2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h200, 32'h3, 1'b0, 1'b0, 1'b1);
        checkOutput("t34_flush_dv", 32'(deq_valid), 32'd0);
        idleCycle(1'b1);
        checkOutput("t34_count", 32'(count), 32'd0);
        checkOutput("t34_deq_valid", 32'(deq_valid), 32'd0);
        checkOutput("t34_enq_ready", 32'(enq_ready), 32'd1);
        idleCycle(1'b1);
        checkOutput("t34_never_deq", 32'(deq_log.size()), 32'd0);

        // Steady state at count=1 with simultaneous enqueue and dequeue
        doReset();
        applyStimulus(1'b1, 32'h0, 32'h50, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 32'(4 * i), 32'(80 + i), 1'b0, 1'b1, 1'b0);
            checkOutput("t35_count", 32'(count), 32'd1);
            checkOutput("t35_order", deq_pc, 32'(4 * (i - 1)));
        end

        // Fault flag stays attached to its own entry
        doReset();
        applyStimulus(1'b1, 32'h300, 32'h7, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h304, 32'h8, 1'b0, 1'b0, 1'b0);
        checkOutput("t36_fault_pc", deq_pc, 32'h300);
        checkOutput("t36_fault_set", 32'(deq_fault), 32'd1);
        idleCycle(1'b1);
        idleCycle(1'b0);
        checkOutput("t36_next_pc", deq_pc, 32'h304);
        checkOutput("t36_next_fault", 32'(deq_fault), 32'd0);

        // Empty-queue arrival with Decode ready
        doReset();
        applyStimulus(1'b1, 32'h400, 32'h9, 1'b0, 1'b1, 1'b0);
`ifdef FETCH_QUEUE_BYPASS_EN
        checkOutput("t37_bypass_dv", 32'(deq_valid), 32'd1);
        checkOutput("t37_bypass_pc", deq_pc, 32'h400);
        idleCycle(1'b0);
        checkOutput("t37_count_after", 32'(count), 32'd0);
`else
        checkOutput("t37_no_bypass_dv", 32'(deq_valid), 32'd0);
        idleCycle(1'b0);
        checkOutput("t37_count_after", 32'(count), 32'd1);
        checkOutput("t37_pc_after", deq_pc, 32'h400);
`endif

        // Randomized traffic with occasional flushes and mid-operation resets
        doReset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                doReset();
            end else begin
                ev = ($urandom_range(0, 3) != 0);
                dr = ($urandom_range(0, 2) != 0);
                fl = ($urandom_range(0, 15) == 0);
                applyStimulus(ev, $urandom, $urandom, 1'($urandom_range(0, 1)), dr, fl);
            end
        end
        idleCycle(1'b0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
